// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared definitions for the sequential shifter: the 2-bit
//               operation encodings and the control state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    // Operation encodings, as presented on the mode input.
    localparam logic [1:0] MODE_SLL = 2'b00;   // logical shift left
    localparam logic [1:0] MODE_SRL = 2'b01;   // logical shift right
    localparam logic [1:0] MODE_SRA = 2'b10;   // arithmetic shift right
    localparam logic [1:0] MODE_ROL = 2'b11;   // rotate left

    // Control states. Explicit 2-bit encoding; 2'b11 is unused and recovers
    // to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-bit shift/rotate step.
//               Applies one 1-bit step of the selected operation to y_in.
// Ports       : y_in  [n-1:0]  value before the step
//               mode  [1:0]    operation select (SLL/SRL/SRA/ROL)
//               y_out [n-1:0]  value after the step
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shifter_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] y_in,
    input  logic [1:0]   mode,
    output logic [n-1:0] y_out
);

    always_comb begin
        y_out = y_in;
        case (mode)
            MODE_SLL: y_out = {y_in[n-2:0], 1'b0};
            MODE_SRL: y_out = {1'b0, y_in[n-1:1]};
            MODE_SRA: y_out = {y_in[n-1], y_in[n-1:1]};   // sign bit replicated
            MODE_ROL: y_out = {y_in[n-2:0], y_in[n-1]};   // MSB wraps to LSB
            default:  y_out = y_in;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Sequential shifter. An accepted start latches the operand,
//               shift distance and operation, then the working register is
//               stepped one bit per clock until the distance is exhausted,
//               followed by a one-cycle done pulse.
// Ports       : clk           sole clock, rising edge
//               rst           synchronous, active-high reset
//               start         request pulse, honoured only in IDLE
//               x     [n-1:0] operand, latched on accepted start
//               shamt [SW-1:0] shift distance, latched on accepted start
//               mode  [1:0]   operation, latched on accepted start
//               busy          high while shifting
//               done          one-cycle completion pulse
//               y     [n-1:0] working register / result
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int n  = 8,
    parameter int SW = $clog2(n)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [n-1:0]  x,
    input  logic [SW-1:0] shamt,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  y
);

    state_t        r_state;
    logic [n-1:0]  r_y;
    logic [SW-1:0] r_cnt;
    logic [1:0]    r_mode;
    logic [n-1:0]  w_step;

    shift_step #(
        .n (n)
    ) u_shift_step (
        .y_in  (r_y),
        .mode  (r_mode),
        .y_out (w_step)
    );

    // The counter holds the number of steps still to apply. The SHIFT state
    // spends one extra cycle observing cnt == 0 before moving to DONE, which
    // gives a uniform latency of shamt+1 cycles in SHIFT (including shamt=0)
    // and means the counter never decrements past zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_SLL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_y     <= x;
                        r_cnt   <= shamt;
                        r_mode  <= mode;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_y   <= w_step;
                        r_cnt <= r_cnt - SW'(1);
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags are decoded directly from the state register, so they are
    // glitch-free and mutually exclusive by construction.
    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);
    assign y    = r_y;

endmodule : seq_shifter
`default_nettype wire

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter n, default 8, data width in bits; legal range n >= 2.
REQ-002 Parameter SW, default $clog2(n), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 x  input  n  operand; latched when start is accepted.
REQ-007 shamt  input  SW  shift distance; latched when start is accepted.
REQ-008 mode  input  2  operation; latched when start is accepted: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle completion pulse, high only in DONE.
REQ-011 y  output  n  working register and result.

Function
REQ-012 The block SHALL implement a three-state machine: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1: at the edge, latch x into y, shamt into counter cnt and mode into mode_r; next state SHIFT.
REQ-014 IDLE with start=0: hold y; remain IDLE.
REQ-015 SHIFT with cnt != 0: at each edge, apply one 1-bit step of mode_r to y, decrement cnt, and remain in SHIFT.
REQ-016 SHIFT with cnt == 0: y unchanged; next state DONE.
REQ-017 DONE: next state IDLE unconditionally.
REQ-018 SLL step SHALL be {y[n-2:0],1'b0}.
REQ-019 SRL step SHALL be {1'b0,y[n-1:1]}.
REQ-020 SRA step SHALL be {y[n-1],y[n-1:1]}.
REQ-021 ROL step SHALL be {y[n-2:0],y[n-1]}.
REQ-022 Latency: if start is sampled at edge E, done SHALL be high in the cycle after edge E+shamt+1; shamt=0 gives done after E+1 with y=x.
REQ-023 start SHALL be ignored in SHIFT and DONE; x, shamt and mode are don't-care outside an accepted start.
REQ-024 y SHALL hold the final result from DONE until the next accepted start.
REQ-025 busy and done SHALL never be high together; both SHALL be low in IDLE.
REQ-026 Maximum shamt (n-1) SHALL complete normally with no counter wrap; SLL/SRL by n-1 leaves at most one surviving bit.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, y=0, cnt=0, mode_r=00, busy=0 and done=0, overriding start.
REQ-028 Reset asserted mid-operation (SHIFT or DONE) SHALL abort the operation with no done pulse; start is accepted on the first edge after rst deasserts.

Structure
REQ-029 Package shifter_pkg SHALL hold the mode encodings (MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL) and the state enumeration type.
REQ-030 The 1-bit step SHALL be a combinational sub-module shift_step (parameter n; ports y_in, mode, y_out), instantiated once.
REQ-031 The state machine, cnt and y register SHALL reside in seq_shifter; busy and done SHALL be decoded from state.

Verification (n=8)
REQ-032 SLL, x=8'h81, shamt=3 -> y=8'h08; done high exactly 4 cycles after the start edge; busy high for 4 cycles.
REQ-033 SRL, x=8'h90, shamt=2 -> y=8'h24; SRA, same x and shamt -> y=8'hE4.
REQ-034 ROL, x=8'h81, shamt=1 -> y=8'h03; ROL, x=8'hA5, shamt=0 -> y=8'hA5 with done 1 cycle after the start edge.
REQ-035 SLL, x=8'hFF, shamt=7 -> y=8'h80; start pulsed during SHIFT with x=8'h00 -> ignored, result unchanged.
REQ-036 Reset asserted on the 2nd SHIFT cycle of SRL x=8'hF0, shamt=5 -> next cycle y=8'h00, busy=0, no done; a new start afterwards completes correctly.
REQ-037 Back-to-back: start held high continuously -> a new operation is accepted on each return to IDLE, with exactly one done pulse per operation.
